// File: rtl/ham_pkg.sv
// Shared types and derived constants for the max-Hamming-distance engine.
package ham_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        CMP,
        WRITE,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_COUNT = 20;

    function automatic int ham_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int HAM_W     = ham_width(DEF_WIDTH);
    localparam int NUM_PAIRS = DEF_COUNT * (DEF_COUNT - 1) / 2;

endpackage

// File: rtl/max_ham_engine_if.sv
// Memory-master bus between the engine and an async-read data memory.
interface max_ham_engine_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
);
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_rd_data;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_wr_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/ham_popcount.sv
// Combinational Hamming distance: popcount of the XOR of two words.
module ham_popcount #(
    parameter int WIDTH = 8,
    parameter int HAM_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [HAM_W-1:0] cnt
);
    logic [WIDTH-1:0] x;

    assign x = a ^ b;

    always_comb begin
        cnt = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cnt = cnt + HAM_W'(x[k]);
        end
    end
endmodule

// File: rtl/max_ham_engine.sv
// Walks all pairs i<j of COUNT bytes at one pair per clock, tracks the largest
// Hamming distance, writes it to RESULT_ADDR and raises Halt.
module max_ham_engine
    import ham_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int AW          = 8,
    parameter int BASE_ADDR   = 128,
    parameter int COUNT       = 20,
    parameter int RESULT_ADDR = 127
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       start,
    max_ham_engine_if.master           mem,
    output logic                       Halt,
    output logic [$clog2(WIDTH+1)-1:0] max_ham,
    output logic [AW-1:0]              max_i,
    output logic [AW-1:0]              max_j
);
    localparam int HW = $clog2(WIDTH + 1);
    localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);
    localparam logic [AW-1:0] BASE_P1 = AW'(BASE_ADDR + 1);
    localparam logic [AW-1:0] LAST    = AW'(BASE_ADDR + COUNT - 1);
    localparam logic [AW-1:0] LAST_M1 = AW'(BASE_ADDR + COUNT - 2);
    localparam logic [AW-1:0] RES     = AW'(RESULT_ADDR);

    state_t           state, state_n;
    logic             armed;
    logic [AW-1:0]    i, j;
    logic [WIDTH-1:0] a;
    logic [HW-1:0]    d;

    ham_popcount #(.WIDTH(WIDTH), .HAM_W(HW)) u_pc (
        .a   (a),
        .b   (mem.mem_rd_data),
        .cnt (d)
    );

    always_comb begin
        state_n         = state;
        mem.mem_addr    = '0;
        mem.mem_wr_en   = 1'b0;
        mem.mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (armed && !start) state_n = (COUNT == 1) ? WRITE : LOAD_A;
            end
            LOAD_A: begin
                mem.mem_addr = i;
                state_n      = CMP;
            end
            CMP: begin
                mem.mem_addr = j;
                if (j == LAST) state_n = (i == LAST_M1) ? WRITE : LOAD_A;
            end
            WRITE: begin
                mem.mem_addr    = RES;
                // An abort landing on the write cycle must not commit the result.
                mem.mem_wr_en   = !start;
                mem.mem_wr_data = WIDTH'(max_ham);
                state_n         = DONE;
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (start) state_n = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            armed   <= 1'b0;
            Halt    <= 1'b0;
            max_ham <= '0;
            max_i   <= '0;
            max_j   <= '0;
            i       <= '0;
            j       <= '0;
            a       <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                armed <= 1'b1;
                Halt  <= 1'b0;
            end
            case (state)
                IDLE: if (armed && !start) begin
                    armed   <= 1'b0;
                    i       <= BASE;
                    max_ham <= '0;
                    max_i   <= BASE;
                    max_j   <= BASE_P1;
                    Halt    <= 1'b0;
                end
                LOAD_A: if (!start) begin
                    a <= mem.mem_rd_data;
                    j <= i + 1'b1;
                end
                CMP: if (!start) begin
                    // Strictly greater keeps the earliest pair on ties.
                    if (d > max_ham) begin
                        max_ham <= d;
                        max_i   <= i;
                        max_j   <= j;
                    end
                    if (j != LAST)          j <= j + 1'b1;
                    else if (i != LAST_M1)  i <= i + 1'b1;
                end
                WRITE: if (!start) Halt <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
